// File: rtl/a51_keystream_core_if.sv
// Signal bundle for the A5/1 keystream core: stage strobes, serial inputs, keystream results and debug state.
// STAGE_ERR is present only when A51_STAGE_CHECK_EN is defined.
interface a51_keystream_core_if;
  // Flow control: there is no ready. The stage counter owns the strobes and the core
  // accepts one serial bit on every strobed cycle. OUT_VALID is high for one cycle
  // after each OUTPUTSTAGE sample and qualifies KS_BIT/DATA_OUT for that cycle only.
  logic        STAGEONE;
  logic        STAGETWO;
  logic        STAGETHREE;
  logic        OUTPUTSTAGE;
  logic        KEY_BIT;
  logic        FRAME_BIT;
  logic        DATA_IN;
  logic        KS_BIT;
  logic        DATA_OUT;
  logic        OUT_VALID;
  logic [2:0]  stage_dbg;
  logic [18:0] r1_dbg;
  logic [21:0] r2_dbg;
  logic [22:0] r3_dbg;
`ifdef A51_STAGE_CHECK_EN
  logic        STAGE_ERR;

  modport master (
    output STAGEONE, STAGETWO, STAGETHREE, OUTPUTSTAGE, KEY_BIT, FRAME_BIT, DATA_IN,
    input  KS_BIT, DATA_OUT, OUT_VALID, stage_dbg, r1_dbg, r2_dbg, r3_dbg, STAGE_ERR
  );
  modport slave (
    input  STAGEONE, STAGETWO, STAGETHREE, OUTPUTSTAGE, KEY_BIT, FRAME_BIT, DATA_IN,
    output KS_BIT, DATA_OUT, OUT_VALID, stage_dbg, r1_dbg, r2_dbg, r3_dbg, STAGE_ERR
  );
`else
  modport master (
    output STAGEONE, STAGETWO, STAGETHREE, OUTPUTSTAGE, KEY_BIT, FRAME_BIT, DATA_IN,
    input  KS_BIT, DATA_OUT, OUT_VALID, stage_dbg, r1_dbg, r2_dbg, r3_dbg
  );
  modport slave (
    input  STAGEONE, STAGETWO, STAGETHREE, OUTPUTSTAGE, KEY_BIT, FRAME_BIT, DATA_IN,
    output KS_BIT, DATA_OUT, OUT_VALID, stage_dbg, r1_dbg, r2_dbg, r3_dbg
  );
`endif
endinterface

// File: rtl/a51_keystream_core.sv
// A5/1 keystream core: three LFSRs keyed, framed and warmed under the stage counter's strobes.
// Optional stage-sequence checker (STAGE_ERR) enabled by defining A51_STAGE_CHECK_EN.
module a51_keystream_core #(
  parameter int KEY_LEN    = 64,
  parameter int FRAME_LEN  = 22,
  parameter int WARMUP_LEN = 100
) (
  input logic                 C,
  input logic                 CLR,
  a51_keystream_core_if.slave bus
);

  localparam logic [2:0] ST_NONE  = 3'd0;
  localparam logic [2:0] ST_KEY   = 3'd1;
  localparam logic [2:0] ST_FRAME = 3'd2;
  localparam logic [2:0] ST_WARM  = 3'd3;
  localparam logic [2:0] ST_OUT   = 3'd4;

  // The stage lengths are fixed by the A5/1 algorithm and the upstream counter.
  if (KEY_LEN != 64 || FRAME_LEN != 22 || WARMUP_LEN != 100) begin : g_param_guard
    $error("a51_keystream_core: stage lengths are fixed at 64/22/100");
  end

  logic [18:0] r1, r1_n;
  logic [21:0] r2, r2_n;
  logic [22:0] r3, r3_n;
  logic [2:0]  cur_stage, prev_stage;
  logic [3:0]  strobes;
  logic        maj, z, key_first;
  logic        ks_q, dout_q, valid_q;

  function automatic logic [18:0] r1_step(input logic [18:0] r, input logic b);
    return {r[17:0], r[13] ^ r[16] ^ r[17] ^ r[18] ^ b};
  endfunction

  function automatic logic [21:0] r2_step(input logic [21:0] r, input logic b);
    return {r[20:0], r[20] ^ r[21] ^ b};
  endfunction

  function automatic logic [22:0] r3_step(input logic [22:0] r, input logic b);
    return {r[21:0], r[7] ^ r[20] ^ r[21] ^ r[22] ^ b};
  endfunction

  assign strobes = {bus.OUTPUTSTAGE, bus.STAGETHREE, bus.STAGETWO, bus.STAGEONE};

  // Anything other than exactly one strobe decodes to NONE and holds the datapath.
  always_comb begin
    cur_stage = ST_NONE;
    case (strobes)
      4'b0001: cur_stage = ST_KEY;
      4'b0010: cur_stage = ST_FRAME;
      4'b0100: cur_stage = ST_WARM;
      4'b1000: cur_stage = ST_OUT;
      default: cur_stage = ST_NONE;
    endcase
  end

  assign maj       = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
  assign key_first = (prev_stage != ST_KEY);

  always_comb begin
    r1_n = r1;
    r2_n = r2;
    r3_n = r3;
    case (cur_stage)
      ST_KEY: begin
        // Entering a key load starts from all-zero registers, also after counter wrap.
        r1_n = r1_step(key_first ? 19'd0 : r1, bus.KEY_BIT);
        r2_n = r2_step(key_first ? 22'd0 : r2, bus.KEY_BIT);
        r3_n = r3_step(key_first ? 23'd0 : r3, bus.KEY_BIT);
      end
      ST_FRAME: begin
        r1_n = r1_step(r1, bus.FRAME_BIT);
        r2_n = r2_step(r2, bus.FRAME_BIT);
        r3_n = r3_step(r3, bus.FRAME_BIT);
      end
      ST_WARM, ST_OUT: begin
        if (r1[8] == maj)  r1_n = r1_step(r1, 1'b0);
        if (r2[10] == maj) r2_n = r2_step(r2, 1'b0);
        if (r3[10] == maj) r3_n = r3_step(r3, 1'b0);
      end
      default: ;
    endcase
  end

  assign z = r1_n[18] ^ r2_n[21] ^ r3_n[22];

  always_ff @(posedge C) begin
    if (CLR) begin
      r1         <= '0;
      r2         <= '0;
      r3         <= '0;
      prev_stage <= ST_NONE;
      ks_q       <= 1'b0;
      dout_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      r1         <= r1_n;
      r2         <= r2_n;
      r3         <= r3_n;
      prev_stage <= cur_stage;
      if (cur_stage == ST_OUT) begin
        ks_q    <= z;
        dout_q  <= bus.DATA_IN ^ z;
        valid_q <= 1'b1;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.KS_BIT    = ks_q;
  assign bus.DATA_OUT  = dout_q;
  assign bus.OUT_VALID = valid_q;
  assign bus.stage_dbg = prev_stage;
  assign bus.r1_dbg    = r1;
  assign bus.r2_dbg    = r2;
  assign bus.r3_dbg    = r3;

`ifdef A51_STAGE_CHECK_EN
  localparam logic [7:0] KEY_RUN   = 8'(KEY_LEN);
  localparam logic [7:0] FRAME_RUN = 8'(FRAME_LEN);
  localparam logic [7:0] WARM_RUN  = 8'(WARMUP_LEN);

  logic [7:0] run_len;
  logic       stage_err;
  logic       multi_strobe;
  logic       legal_move;

  assign multi_strobe = ($countones(strobes) > 1);
  assign legal_move   = (prev_stage == ST_KEY   && cur_stage == ST_FRAME) ||
                        (prev_stage == ST_FRAME && cur_stage == ST_WARM)  ||
                        (prev_stage == ST_WARM  && cur_stage == ST_OUT)   ||
                        (prev_stage == ST_OUT   && cur_stage == ST_KEY);

  // run_len holds the length of the run that prev_stage belongs to; it is judged when that run ends.
  always_ff @(posedge C) begin
    if (CLR) begin
      run_len   <= 8'd0;
      stage_err <= 1'b0;
    end else begin
      if (cur_stage == prev_stage) begin
        if (run_len != 8'hFF) run_len <= run_len + 8'd1;
      end else begin
        run_len <= 8'd1;
      end
      if (multi_strobe) stage_err <= 1'b1;
      if (cur_stage != prev_stage && prev_stage != ST_NONE) begin
        if (prev_stage == ST_KEY && run_len != KEY_RUN && run_len != KEY_RUN + 8'd1)
          stage_err <= 1'b1;
        if (prev_stage == ST_FRAME && run_len != FRAME_RUN) stage_err <= 1'b1;
        if (prev_stage == ST_WARM && run_len != WARM_RUN)   stage_err <= 1'b1;
        if (cur_stage != ST_NONE && !legal_move)           stage_err <= 1'b1;
      end
    end
  end

  assign bus.STAGE_ERR = stage_err;
`endif

endmodule
